// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with single-outstanding imem handshake and a prefetch queue.
// Optional IFU_STATS_EN adds fetch/discard counter outputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
`ifdef IFU_STATS_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_discard_cnt
`endif
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t state;
    logic [31:0] pc_q [DEPTH];
    logic [31:0] inst_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [31:0] fetch_pc, target;
    logic ack, push, pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign ack = imem_req && imem_ack;
    assign push = ack && state == REQ && !redirect;
    assign pop = !stall && count != '0 && !redirect;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign target = {redirect_pc[31:2], 2'b00};
    assign if_valid = count != '0;
    assign if_pc = if_valid ? pc_q[rd_ptr] : 32'h0;
    assign if_inst = if_valid ? inst_q[rd_ptr] : 32'h0;
    always_ff @(posedge clk)
        if (push) begin
            pc_q[wr_ptr] <= fetch_pc;
            inst_q[wr_ptr] <= imem_rdata;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            imem_req <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            fetch_pc <= target;
            imem_req <= 1'b1;
            // an unanswered request must complete at its old address before restarting
            if (imem_req && !imem_ack)
                state <= DRAIN;
            else begin
                state <= REQ;
                imem_addr <= target;
            end
        end else begin
            if (push) begin
                wr_ptr <= inc(wr_ptr);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= inc(rd_ptr);
            count <= count_nxt;
            case (state)
                IDLE:
                    if (count < DEPTH_C) begin
                        state <= REQ;
                        imem_req <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                REQ:
                    if (ack) begin
                        imem_addr <= fetch_pc + 32'd4;
                        if (count_nxt >= DEPTH_C) begin
                            state <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                DRAIN:
                    if (ack) begin
                        state <= REQ;
                        imem_addr <= fetch_pc;
                    end
                default: begin
                    state <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
`ifdef IFU_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stat_fetch_cnt <= '0;
            stat_discard_cnt <= '0;
        end else begin
            if (push)
                stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            stat_discard_cnt <= stat_discard_cnt
                + 32'(ack && (state == DRAIN || redirect))
                + (redirect ? 32'(count) : 32'd0);
        end
`endif
endmodule
